// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states, frame width and counter helpers.
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 16;
    localparam int unsigned SPI_CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        XFER  = 2'd2
    } state_t;

    // Saturating increment so runaway SCLK bursts cannot wrap back to a valid count.
    function automatic logic [SPI_CNT_W-1:0] sat_inc(input logic [SPI_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + SPI_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync3.sv
// 1-bit 3-flop synchronizer: flops 1-2 resolve metastability, flops 2-3 detect edges.
module spi_sync3 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic ff1, ff2, ff3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= RST_VAL;
            ff2 <= RST_VAL;
            ff3 <= RST_VAL;
        end else begin
            ff1 <= din;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign sync   = ff2;
    assign rise_c = ff2 & ~ff3;
    assign fall_c = ~ff2 & ff3;

endmodule

// File: rtl/spi_resp16.sv
// 16-bit SPI responder (slave). Define SPI_RESP_OVR_EN to enable the overrun flag;
// otherwise ovr is tied low.
module spi_resp16
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SPI_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  wrt_tx,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rdy,
    input  logic                  clr_rdy,
    output logic                  ovr
);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_sync3 #(.RST_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (SS_n),
        .sync   (ss_sync),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    spi_sync3 #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (SCLK),
        .sync   (sclk_sync),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync3 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (MOSI),
        .sync   (mosi_sync),
        .rise_c (mosi_rise),
        .fall_c (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, ss_sync, sclk_sync, mosi_rise, mosi_fall};

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  tx_buf_q;
    logic [FRAME_BITS-1:0]  shft_q, shft_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [SPI_CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [SPI_CNT_W-1:0]   shcnt_q, shcnt_d;
    logic                   smpl_q, smpl_d;
    logic                   rdy_q, rdy_d;
    logic                   done_c;

    // Next-state and datapath; a frame is valid only with exactly 16 rises and 16 shifts.
    always_comb begin
        state_d  = state_q;
        shft_d   = shft_q;
        rx_d     = rx_q;
        bitcnt_d = bitcnt_q;
        shcnt_d  = shcnt_q;
        smpl_d   = smpl_q;
        rdy_d    = rdy_q;
        done_c   = 1'b0;

        if (clr_rdy) rdy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    shft_d   = wrt_tx ? tx_data : tx_buf_q;
                    bitcnt_d = '0;
                    shcnt_d  = '0;
                    rdy_d    = 1'b0;
                    state_d  = FRONT;
                end
            end
            FRONT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    smpl_d   = mosi_sync;
                    bitcnt_d = sat_inc(bitcnt_q);
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    done_c  = (bitcnt_q == SPI_CNT_W'(FRAME_BITS)) &&
                              (shcnt_q >= SPI_CNT_W'(FRAME_BITS));
                end else begin
                    if (sclk_fall) begin
                        shft_d  = {shft_q[FRAME_BITS-2:0], smpl_q};
                        shcnt_d = sat_inc(shcnt_q);
                    end
                    if (sclk_rise) begin
                        smpl_d   = mosi_sync;
                        bitcnt_d = sat_inc(bitcnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (done_c) begin
            rx_d  = shft_q;
            rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tx_buf_q <= '0;
            shft_q   <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            shcnt_q  <= '0;
            smpl_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shft_q   <= shft_d;
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            shcnt_q  <= shcnt_d;
            smpl_q   <= smpl_d;
            rdy_q    <= rdy_d;
            if (wrt_tx) tx_buf_q <= tx_data;
        end
    end

    assign MISO    = shft_q[FRAME_BITS-1];
    assign rx_data = rx_q;
    assign rdy     = rdy_q;

`ifdef SPI_RESP_OVR_EN
    // pend tracks an unacknowledged frame; rdy itself drops at the next ss_fall.
    logic pend_q, ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (done_c)       pend_q <= 1'b1;
            else if (clr_rdy) pend_q <= 1'b0;
            if (done_c && pend_q) ovr_q <= 1'b1;
            else if (clr_rdy)     ovr_q <= 1'b0;
        end
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_resp16.sv
// Directed bench for spi_resp16: table of whole frames plus hand-written corner sequences.
module tb_spi_resp16;

    localparam int HALF = 8;
`ifdef SPI_RESP_OVR_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic        wrt_tx;
    logic [15:0] rx_data;
    logic        rdy;
    logic        clr_rdy;
    logic        ovr;

    int checks;
    int errors;

    spi_resp16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt_tx  (wrt_tx),
        .rx_data (rx_data),
        .rdy     (rdy),
        .clr_rdy (clr_rdy),
        .ovr     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] mosi;
        int          nrise;
        logic [15:0] exp_rx;
        logic        exp_rdy;
        bit          chk_miso;
    } vec_t;

    vec_t vecs[5];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] val);
        tx_data = val;
        wrt_tx  = 1'b1;
        wait_clk(1);
        wrt_tx  = 1'b0;
        wait_clk(1);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        wait_clk(1);
        clr_rdy = 1'b0;
        wait_clk(1);
    endtask

    // Master model: SS_n fall, front fall, nrise x (rise, fall), SS_n rise, SCLK back high.
    task automatic run_frame(input logic [15:0] mosi_w, input int nrise,
                             input int load_at, input logic [15:0] load_val,
                             input bit byp, input logic [15:0] byp_val,
                             input bit fin, input bit clr_end,
                             output logic [15:0] miso_w);
        miso_w = '0;
        SS_n   = 1'b0;
        if (byp) begin
            wait_clk(2);
            tx_data = byp_val;
            wrt_tx  = 1'b1;
            wait_clk(1);
            wrt_tx  = 1'b0;
            wait_clk(HALF - 3);
        end else begin
            wait_clk(HALF);
        end
        SCLK = 1'b0;
        MOSI = mosi_w[15];
        wait_clk(HALF);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b1;
            if (i < 16) miso_w[15-i] = MISO;
            if (i == load_at) begin
                tx_data = load_val;
                wrt_tx  = 1'b1;
                wait_clk(1);
                wrt_tx  = 1'b0;
                wait_clk(HALF - 1);
            end else begin
                wait_clk(HALF);
            end
            SCLK = 1'b0;
            if (14 - i >= 0) MOSI = mosi_w[14-i];
            else             MOSI = 1'b0;
            wait_clk(HALF);
        end
        if (fin) begin
            SS_n = 1'b1;
            if (clr_end) begin
                wait_clk(2);
                clr_rdy = 1'b1;
                wait_clk(1);
                clr_rdy = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
            SCLK = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        logic [15:0] m;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        tx_data = '0;
        wrt_tx  = 1'b0;
        clr_rdy = 1'b0;

        vecs[0] = '{tx: 16'hA5C3, mosi: 16'h1234, nrise: 16, exp_rx: 16'h1234, exp_rdy: 1'b1, chk_miso: 1'b1};
        vecs[1] = '{tx: 16'h0000, mosi: 16'h5555, nrise: 9,  exp_rx: 16'h1234, exp_rdy: 1'b0, chk_miso: 1'b0};
        vecs[2] = '{tx: 16'h3C3C, mosi: 16'hFFFF, nrise: 16, exp_rx: 16'hFFFF, exp_rdy: 1'b1, chk_miso: 1'b1};
        vecs[3] = '{tx: 16'h1357, mosi: 16'h0000, nrise: 20, exp_rx: 16'hFFFF, exp_rdy: 1'b0, chk_miso: 1'b1};
        vecs[4] = '{tx: 16'hFFFF, mosi: 16'h8421, nrise: 16, exp_rx: 16'h8421, exp_rdy: 1'b1, chk_miso: 1'b1};

        wait_clk(3);
        chk("reset_miso", 16'(MISO), 16'h0);
        chk("reset_rx", rx_data, 16'h0000);
        chk("reset_rdy", 16'(rdy), 16'h0);
        chk("reset_ovr", 16'(ovr), 16'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Table: full, aborted and over-long frames, each preceded by an acknowledge.
        for (int v = 0; v < 5; v++) begin
            pulse_clr();
            load(vecs[v].tx);
            run_frame(vecs[v].mosi, vecs[v].nrise, -1, '0, 1'b0, '0, 1'b1, 1'b0, m);
            chk($sformatf("vec%0d_rx", v), rx_data, vecs[v].exp_rx);
            chk($sformatf("vec%0d_rdy", v), 16'(rdy), 16'(vecs[v].exp_rdy));
            chk($sformatf("vec%0d_ovr", v), 16'(ovr), 16'h0);
            if (vecs[v].chk_miso) chk($sformatf("vec%0d_miso", v), m, vecs[v].tx);
        end

        // tx_buf written mid-frame only affects the following frame.
        pulse_clr();
        load(16'h00FF);
        run_frame(16'hAAAA, 16, 5, 16'h0F0F, 1'b0, '0, 1'b1, 1'b0, m);
        chk("midload_cur_miso", m, 16'h00FF);
        chk("midload_cur_rx", rx_data, 16'hAAAA);
        pulse_clr();
        run_frame(16'h5555, 16, -1, '0, 1'b0, '0, 1'b1, 1'b0, m);
        chk("midload_next_miso", m, 16'h0F0F);
        chk("midload_next_rx", rx_data, 16'h5555);

        // wrt_tx coincident with the synchronized ss_fall goes straight to the shifter.
        pulse_clr();
        run_frame(16'h0001, 16, -1, '0, 1'b1, 16'h8001, 1'b1, 1'b0, m);
        chk("bypass_miso", m, 16'h8001);
        chk("bypass_rx", rx_data, 16'h0001);

        // Two completions without acknowledge, then clr_rdy colliding with a completion.
        pulse_clr();
        load(16'h0000);
        run_frame(16'h1111, 16, -1, '0, 1'b0, '0, 1'b1, 1'b0, m);
        chk("ovr_first_ovr", 16'(ovr), 16'h0);
        run_frame(16'h2222, 16, -1, '0, 1'b0, '0, 1'b1, 1'b0, m);
        chk("ovr_rx", rx_data, 16'h2222);
        chk("ovr_rdy", 16'(rdy), 16'h1);
        chk("ovr_flag", 16'(ovr), 16'(OVR_EXP));
        run_frame(16'h3333, 16, -1, '0, 1'b0, '0, 1'b1, 1'b1, m);
        chk("prio_rdy", 16'(rdy), 16'h1);
        chk("prio_rx", rx_data, 16'h3333);
        chk("prio_ovr", 16'(ovr), 16'(OVR_EXP));
        pulse_clr();
        chk("ack_rdy", 16'(rdy), 16'h0);
        chk("ack_ovr", 16'(ovr), 16'h0);

        // Asynchronous reset in the middle of a frame, then a clean frame.
        load(16'hFFFF);
        run_frame(16'hBEEF, 8, -1, '0, 1'b0, '0, 1'b0, 1'b0, m);
        chk("premid_miso", 16'(MISO), 16'h1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst_miso", 16'(MISO), 16'h0);
        chk("midrst_rx", rx_data, 16'h0000);
        chk("midrst_rdy", 16'(rdy), 16'h0);
        chk("midrst_ovr", 16'(ovr), 16'h0);
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(8);
        load(16'hC0DE);
        run_frame(16'hBEEF, 16, -1, '0, 1'b0, '0, 1'b1, 1'b0, m);
        chk("postrst_rx", rx_data, 16'hBEEF);
        chk("postrst_rdy", 16'(rdy), 16'h1);
        chk("postrst_miso", m, 16'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
